cpu_if: RTL and testbench

//  Instruction fetch stage; the producer side of the if_pc/if_inst interface consumed by decode (cpu_id).

---
 rtl/cpu_if.sv | 211 +++++++++++++++++++++
 tb/tb_cpu_if.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_if
//  Description : Instruction fetch stage. Holds the PC, runs req/ack fetches
//                against instruction memory and registers if_pc/if_inst for
//                decode. Handles global freeze, decode stall, EX redirects
//                and interrupt flush.
//  Options     : CPU_IF_EPC_EN - adds the epc output/register.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_if #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] INT_VECTOR   = 32'h0000_0004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_stall,
    input  logic        c_stall,
    input  logic        c_redirect,
    input  logic [31:0] redirect_pc,
    input  logic        int_flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
`ifdef CPU_IF_EPC_EN
    output logic [31:0] epc,
`endif
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        BUF     = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] addr_nxt;
    logic        req_nxt;
    logic [31:0] if_pc_nxt, if_inst_nxt;
    logic [31:0] buf_inst, buf_inst_nxt;
    logic [31:0] buf_pc, buf_pc_nxt;
    // Set when pc already holds a redirect target while a word sits in the
    // buffer, so release must fetch pc itself rather than pc+4.
    logic        buf_redir, buf_redir_nxt;

    logic        ack;
    logic        stall;
    logic        redirect_ok;
    logic        flush_ok;
    logic        outstanding;

    // An ack only means something while a request is actually on the bus.
    assign ack         = imem_ack & imem_req;
    assign stall       = cpu_stall | c_stall;
    // Redirect and flush sources are frozen by cpu_stall and re-present later.
    assign redirect_ok = c_redirect & ~cpu_stall;
    assign flush_ok    = int_flush & ~cpu_stall;
    assign outstanding = imem_req & ~ack;

    // Next-state and datapath decisions; everything holds unless changed.
    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        addr_nxt      = imem_addr;
        req_nxt       = imem_req;
        if_pc_nxt     = if_pc;
        if_inst_nxt   = if_inst;
        buf_inst_nxt  = buf_inst;
        buf_pc_nxt    = buf_pc;
        buf_redir_nxt = buf_redir;

        if (flush_ok) begin
            if_inst_nxt   = 32'h0;
            if_pc_nxt     = 32'h0;
            buf_inst_nxt  = 32'h0;
            buf_pc_nxt    = 32'h0;
            buf_redir_nxt = 1'b0;
            pc_nxt        = INT_VECTOR;
            req_nxt       = 1'b1;
            if (outstanding) begin
                state_nxt = DISCARD;
            end else begin
                addr_nxt  = INT_VECTOR;
                state_nxt = FETCH;
            end
        end else begin
            case (state)
                FETCH: begin
                    req_nxt = 1'b1;
                    if (ack) begin
                        if (stall) begin
                            // Park the word until the pipe can take it.
                            buf_inst_nxt  = imem_rdata;
                            buf_pc_nxt    = imem_addr;
                            buf_redir_nxt = redirect_ok;
                            req_nxt       = 1'b0;
                            state_nxt     = BUF;
                            if (redirect_ok) begin
                                pc_nxt = redirect_pc;
                            end
                        end else begin
                            // Word acked alongside a redirect is the delay slot.
                            if_inst_nxt = imem_rdata;
                            if_pc_nxt   = imem_addr;
                            pc_nxt      = redirect_ok ? redirect_pc : pc + 32'd4;
                            addr_nxt    = redirect_ok ? redirect_pc : pc + 32'd4;
                        end
                    end else begin
                        if (!stall) begin
                            if_inst_nxt = 32'h0;
                        end
                        if (redirect_ok) begin
                            pc_nxt = redirect_pc;
                            if (outstanding) begin
                                state_nxt = DISCARD;
                            end else begin
                                addr_nxt = redirect_pc;
                            end
                        end
                    end
                end

                BUF: begin
                    req_nxt = 1'b0;
                    if (redirect_ok) begin
                        pc_nxt        = redirect_pc;
                        buf_redir_nxt = 1'b1;
                    end
                    if (!stall) begin
                        if_inst_nxt   = buf_inst;
                        if_pc_nxt     = buf_pc;
                        if (redirect_ok) begin
                            pc_nxt   = redirect_pc;
                            addr_nxt = redirect_pc;
                        end else if (buf_redir) begin
                            pc_nxt   = pc;
                            addr_nxt = pc;
                        end else begin
                            pc_nxt   = pc + 32'd4;
                            addr_nxt = pc + 32'd4;
                        end
                        buf_redir_nxt = 1'b0;
                        req_nxt       = 1'b1;
                        state_nxt     = FETCH;
                    end
                end

                DISCARD: begin
                    // The stale fetch must complete before the new address goes out.
                    req_nxt = 1'b1;
                    if (!stall) begin
                        if_inst_nxt = 32'h0;
                    end
                    if (redirect_ok) begin
                        pc_nxt = redirect_pc;
                    end
                    if (ack) begin
                        addr_nxt  = redirect_ok ? redirect_pc : pc;
                        state_nxt = FETCH;
                    end
                end

                default: begin
                    state_nxt = FETCH;
                end
            endcase
        end
    end

    // State register; reset overrides everything including a pending ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            pc        <= RESET_VECTOR;
            imem_addr <= RESET_VECTOR;
            imem_req  <= 1'b0;
            if_pc     <= 32'h0;
            if_inst   <= 32'h0;
            buf_inst  <= 32'h0;
            buf_pc    <= 32'h0;
            buf_redir <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            imem_addr <= addr_nxt;
            imem_req  <= req_nxt;
            if_pc     <= if_pc_nxt;
            if_inst   <= if_inst_nxt;
            buf_inst  <= buf_inst_nxt;
            buf_pc    <= buf_pc_nxt;
            buf_redir <= buf_redir_nxt;
        end
    end

`ifdef CPU_IF_EPC_EN
    // Exception PC: last valid decode PC, or the next fetch PC if decode holds a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            epc <= 32'h0;
        end else if (flush_ok) begin
            epc <= (if_inst != 32'h0) ? if_pc : pc;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_if.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_if
//  Description : Directed self-checking bench for cpu_if. The memory model
//                answers with rdata = addr ^ 32'hA5A5_0000.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_stall;
    logic        c_stall;
    logic        c_redirect;
    logic [31:0] redirect_pc;
    logic        int_flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
`ifdef CPU_IF_EPC_EN
    logic [31:0] epc;
`endif

    logic        ack_en;
    int          total = 0;
    int          bad   = 0;

    localparam logic [31:0] SALT = 32'hA5A5_0000;

    always #5 clk = ~clk;

    // Memory answers in the request cycle whenever the bench enables it.
    assign imem_ack   = ack_en & imem_req;
    assign imem_rdata = imem_addr ^ SALT;

    cpu_if dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_stall   (cpu_stall),
        .c_stall     (c_stall),
        .c_redirect  (c_redirect),
        .redirect_pc (redirect_pc),
        .int_flush   (int_flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
`ifdef CPU_IF_EPC_EN
        .epc         (epc),
`endif
        .if_pc       (if_pc),
        .if_inst     (if_inst)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; cpu_stall = 1'b0; c_stall = 1'b0; c_redirect = 1'b0;
        redirect_pc = 32'h0; int_flush = 1'b0; ack_en = 1'b0;

        // 1. Reset, then zero-wait streaming
        tick(); tick();
        chk("rst_req",  {31'h0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_pc",   if_pc, 32'h0);
        chk("rst_inst", if_inst, 32'h0);
        rst = 1'b0;
        tick();
        chk("req_rise", {31'h0, imem_req}, 32'h1);
        ack_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stream_pc",   if_pc, 32'(i * 4));
            chk("stream_inst", if_inst, 32'(i * 4) ^ SALT);
        end

        // 2. Slow memory: ack in the third request cycle
        ack_en = 1'b0;
        tick();
        chk("slow_b1_inst", if_inst, 32'h0);
        chk("slow_b1_pc",   if_pc, 32'hC);
        chk("slow_b1_addr", imem_addr, 32'h10);
        tick();
        chk("slow_b2_inst", if_inst, 32'h0);
        chk("slow_b2_addr", imem_addr, 32'h10);
        ack_en = 1'b1;
        tick();
        chk("slow_pc",   if_pc, 32'h10);
        chk("slow_inst", if_inst, 32'h10 ^ SALT);
        chk("slow_next", imem_addr, 32'h14);

        // 3. Decode stall with an ack buffers the word
        c_stall = 1'b1;
        tick();
        chk("cst1_pc",  if_pc, 32'h10);
        chk("cst1_req", {31'h0, imem_req}, 32'h0);
        tick();
        chk("cst2_pc",   if_pc, 32'h10);
        chk("cst2_inst", if_inst, 32'h10 ^ SALT);
        c_stall = 1'b0;
        tick();
        chk("buf_pc",   if_pc, 32'h14);
        chk("buf_inst", if_inst, 32'h14 ^ SALT);
        chk("buf_addr", imem_addr, 32'h18);
        chk("buf_req",  {31'h0, imem_req}, 32'h1);
        tick();
        chk("after_buf_pc", if_pc, 32'h18);
        tick();
        chk("pre_redir_pc", if_pc, 32'h1C);
        chk("pre_redir_addr", imem_addr, 32'h20);

        // 4. Redirect while the fetch at 0x20 is outstanding
        ack_en = 1'b0; c_redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        c_redirect = 1'b0;
        chk("dis1_addr", imem_addr, 32'h20);
        chk("dis1_inst", if_inst, 32'h0);
        tick();
        chk("dis2_inst", if_inst, 32'h0);
        ack_en = 1'b1;
        tick();
        chk("dis_drop_inst", if_inst, 32'h0);
        chk("dis_drop_pc",   if_pc, 32'h1C);
        chk("dis_new_addr",  imem_addr, 32'h100);
        tick();
        chk("tgt_pc",   if_pc, 32'h100);
        chk("tgt_inst", if_inst, 32'h100 ^ SALT);

        // 5. Interrupt flush ignored under freeze, accepted afterwards
        cpu_stall = 1'b1; int_flush = 1'b1;
        tick();
        chk("frz_pc",   if_pc, 32'h100);
        chk("frz_inst", if_inst, 32'h100 ^ SALT);
        cpu_stall = 1'b0;
        tick();
        int_flush = 1'b0;
        chk("flush_inst", if_inst, 32'h0);
        chk("flush_pc",   if_pc, 32'h0);
        chk("flush_addr", imem_addr, 32'h4);
        chk("flush_req",  {31'h0, imem_req}, 32'h1);
`ifdef CPU_IF_EPC_EN
        chk("flush_epc", epc, 32'h100);
`endif
        tick();
        chk("int_pc",   if_pc, 32'h4);
        chk("int_inst", if_inst, 32'h4 ^ SALT);

        // 6. Redirect with same-cycle ack (delay slot), PC wrap, reset mid-fetch
        c_redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        c_redirect = 1'b0;
        chk("slot_pc",   if_pc, 32'h8);
        chk("slot_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_pc",   if_pc, 32'hFFFF_FFFC);
        chk("wrap_inst", if_inst, 32'h5A5A_FFFC);
        chk("wrap_addr", imem_addr, 32'h0);
        tick();
        chk("post_wrap_addr", imem_addr, 32'h4);
        rst = 1'b1;
        tick();
        chk("mid_rst_req",  {31'h0, imem_req}, 32'h0);
        chk("mid_rst_addr", imem_addr, 32'h0);
        chk("mid_rst_inst", if_inst, 32'h0);
        chk("mid_rst_pc",   if_pc, 32'h0);
        rst = 1'b0;
        tick();
        chk("rerun_req", {31'h0, imem_req}, 32'h1);
        tick();
        chk("rerun_pc",   if_pc, 32'h0);
        chk("rerun_inst", if_inst, SALT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
